// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Byte-stream boot controller. Receives a framed program image over a
//   valid/ready byte link, writes it word by word into the instruction
//   memory and releases the core from reset once the frame checksum matches.
//
//   Frame: 0xA5, N[7:0], N[15:8], 4*N payload bytes (little-endian words),
//          checksum = XOR of all payload bytes.
//
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     rx_data/rx_valid    incoming byte stream
//     rx_ready            byte accepted when rx_valid && rx_ready
//     halt_req            stop the core and return to IDLE (from RUN or ERR)
//     imem_we/addr/wdata  instruction memory write port
//     core_reset_n        active-low reset to the core
//     busy                frame in progress (LEN_LO..CSUM)
//     load_done/load_err  status of the last frame
//     words_loaded        words written in the current/last frame
//
//   Optional build macro: IMEM_BOOT_TIMEOUT_EN enables an inter-byte timeout
//   of TIMEOUT_CYCLES clocks while a frame is in progress.
module imem_boot_loader #(
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   input  logic                  halt_req,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_wdata,
   output logic                  core_reset_n,
   output logic                  busy,
   output logic                  load_done,
   output logic                  load_err,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RUN, S_ERR
   } state_t;

   localparam logic [7:0]  HDR       = 8'hA5;
   localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

   state_t                  state_q, state_d;
   logic [15:0]             count_q, count_d;
   logic [1:0]              bidx_q, bidx_d;
   logic [23:0]             wbuf_q, wbuf_d;
   logic [7:0]              csum_q, csum_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    core_rst_n_q, core_rst_n_d;
   logic                    rx_rdy_q, rx_rdy_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic [ADDR_WIDTH:0]     words_q, words_d;
   logic                    accept;
   logic [16:0]             n_words;

`ifdef IMEM_BOOT_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]           tmo_q, tmo_d;
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

   assign accept  = rx_valid && rx_rdy_q;
   assign n_words = {1'b0, rx_data, count_q[7:0]};

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      bidx_d       = bidx_q;
      wbuf_d       = wbuf_q;
      csum_d       = csum_q;
      we_d         = 1'b0;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      core_rst_n_d = core_rst_n_q;
      rx_rdy_d     = rx_rdy_q;
      busy_d       = busy_q;
      done_d       = done_q;
      err_d        = err_q;
      words_d      = words_q;

      case (state_q)
         S_IDLE, S_ERR: begin
            if (halt_req && state_q == S_ERR) begin
               state_d = S_IDLE;
            end else if (accept && rx_data == HDR) begin
               state_d = S_LEN_LO;
               csum_d  = '0;
               words_d = '0;
               bidx_d  = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               count_d[7:0] = rx_data;
               state_d      = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               count_d[15:8] = rx_data;
               if (n_words > MAX_WORDS) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
                  busy_d  = 1'b0;
               end else if (n_words == '0) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               csum_d = csum_q ^ rx_data;
               bidx_d = bidx_q + 2'd1;
               wbuf_d = {rx_data, wbuf_q[23:8]};
               if (bidx_q == 2'd3) begin
                  // Word index equals the number of words already written.
                  we_d    = 1'b1;
                  addr_d  = words_q[ADDR_WIDTH-1:0];
                  wdata_d = DATA_WIDTH'({rx_data, wbuf_q});
                  words_d = words_q + (ADDR_WIDTH + 1)'(1);
                  if ((17'(words_q) + 17'd1) == {1'b0, count_q})
                     state_d = S_CSUM;
               end
            end
         end
         S_CSUM: begin
            if (accept) begin
               busy_d = 1'b0;
               if (rx_data == csum_q) begin
                  state_d      = S_RUN;
                  core_rst_n_d = 1'b1;
                  done_d       = 1'b1;
                  rx_rdy_d     = 1'b0;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (halt_req) begin
               state_d      = S_IDLE;
               core_rst_n_d = 1'b0;
               rx_rdy_d     = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

`ifdef IMEM_BOOT_TIMEOUT_EN
      tmo_d = '0;
      if (state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM} && !accept) begin
         if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         count_q      <= '0;
         bidx_q       <= '0;
         wbuf_q       <= '0;
         csum_q       <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         core_rst_n_q <= 1'b0;
         rx_rdy_q     <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         words_q      <= '0;
`ifdef IMEM_BOOT_TIMEOUT_EN
         tmo_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         bidx_q       <= bidx_d;
         wbuf_q       <= wbuf_d;
         csum_q       <= csum_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         core_rst_n_q <= core_rst_n_d;
         rx_rdy_q     <= rx_rdy_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         words_q      <= words_d;
`ifdef IMEM_BOOT_TIMEOUT_EN
         tmo_q        <= tmo_d;
`endif
      end
   end

   assign rx_ready     = rx_rdy_q;
   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign core_reset_n = core_rst_n_q;
   assign busy         = busy_q;
   assign load_done    = done_q;
   assign load_err     = err_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: directed frames, with a write scoreboard
// (expected imem writes queued at stimulus time, popped by a monitor).
module tb_imem_boot_loader;

   localparam int unsigned AW = 10;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;

   typedef logic [7:0] bq_t[$];

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_ready;
   logic          halt_req = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_reset_n;
   logic          busy;
   logic          load_done;
   logic          load_err;
   logic [AW:0]   words_loaded;

   int n_cmp = 0;
   int n_err = 0;
   wr_t exp_q[$];
   bq_t frame;

   imem_boot_loader #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(32),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .halt_req(halt_req),
      .imem_we(imem_we),
      .imem_addr(imem_addr),
      .imem_wdata(imem_wdata),
      .core_reset_n(core_reset_n),
      .busy(busy),
      .load_done(load_done),
      .load_err(load_err),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Write monitor: every imem_we cycle must match the oldest expected write.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (reset_n && imem_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_write: got addr=0x%0h data=0x%08h expected none",
                        imem_addr, imem_wdata);
            end else begin
               e = exp_q.pop_front();
               if (imem_addr !== e.a || imem_wdata !== e.d) begin
                  n_err++;
                  $display("FAIL imem_write: got addr=0x%0h data=0x%08h expected addr=0x%0h data=0x%08h",
                           imem_addr, imem_wdata, e.a, e.d);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
   endtask

   task automatic send_seq(input bq_t q);
      foreach (q[i]) send_byte(q[i]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
   endtask

   task automatic halt_pulse();
      @(negedge clk);
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
   endtask

   task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_core_reset_n"}, 32'(core_reset_n), 32'd0);
      chk({tag, "_rx_ready"},     32'(rx_ready),     32'd1);
      chk({tag, "_busy"},         32'(busy),         32'd0);
      chk({tag, "_imem_we"},      32'(imem_we),      32'd0);
      chk({tag, "_imem_addr"},    32'(imem_addr),    32'd0);
      chk({tag, "_imem_wdata"},   imem_wdata,        32'd0);
      chk({tag, "_load_done"},    32'(load_done),    32'd0);
      chk({tag, "_load_err"},     32'(load_err),     32'd0);
      chk({tag, "_words"},        32'(words_loaded), 32'd0);
   endtask

   // Good two-word frame; checksum 13^93^10 = 0x90.
   task automatic good_frame();
      push_wr(10'd0, 32'h0000_0013);
      push_wr(10'd1, 32'h0010_0093);
      frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00};
      send_seq(frame);
      send_byte(8'h90);
      chk("pre_csum_core_reset_n", 32'(core_reset_n), 32'd0);
      chk("pre_csum_busy", 32'(busy), 32'd1);
      idle(1);
      chk("run_core_reset_n", 32'(core_reset_n), 32'd1);
      chk("run_load_done", 32'(load_done), 32'd1);
      chk("run_load_err", 32'(load_err), 32'd0);
      chk("run_rx_ready", 32'(rx_ready), 32'd0);
      chk("run_busy", 32'(busy), 32'd0);
      chk("run_words", 32'(words_loaded), 32'd2);
   endtask

   initial begin
      // 1. reset and discarded bytes in IDLE
      @(negedge clk);
      chk_reset_vals("rst");
      @(negedge clk);
      reset_n = 1'b1;
      send_byte(8'h00);
      send_byte(8'h13);
      idle(2);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_rx_ready", 32'(rx_ready), 32'd1);
      chk("idle_core_reset_n", 32'(core_reset_n), 32'd0);

      // 2. good frame, then halt from RUN
      good_frame();
      halt_pulse();
      chk("halt_core_reset_n", 32'(core_reset_n), 32'd0);
      chk("halt_rx_ready", 32'(rx_ready), 32'd1);
      chk("halt_load_done_kept", 32'(load_done), 32'd1);

      // 3. bad checksum, then recover with the good frame
      push_wr(10'd0, 32'h0000_0013);
      push_wr(10'd1, 32'h0010_0093);
      frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
      send_seq(frame);
      idle(1);
      chk("bad_load_err", 32'(load_err), 32'd1);
      chk("bad_load_done", 32'(load_done), 32'd0);
      chk("bad_core_reset_n", 32'(core_reset_n), 32'd0);
      chk("bad_rx_ready", 32'(rx_ready), 32'd1);
      chk("bad_busy", 32'(busy), 32'd0);
      send_byte(8'hA5);
      idle(1);
      chk("hdr_clears_err", 32'(load_err), 32'd0);
      chk("hdr_sets_busy", 32'(busy), 32'd1);
      chk("hdr_clears_words", 32'(words_loaded), 32'd0);
      halt_pulse(); // ignored mid-frame
      chk("halt_ignored_busy", 32'(busy), 32'd1);
      push_wr(10'd0, 32'h0000_0013);
      push_wr(10'd1, 32'h0010_0093);
      frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
      send_seq(frame);
      idle(1);
      chk("recover_load_done", 32'(load_done), 32'd1);
      chk("recover_core_reset_n", 32'(core_reset_n), 32'd1);
      halt_pulse();

      // 4. oversize count, then empty frame from ERR
      frame = '{8'hA5, 8'h01, 8'h04};
      send_seq(frame);
      idle(1);
      chk("oversize_load_err", 32'(load_err), 32'd1);
      chk("oversize_busy", 32'(busy), 32'd0);
      frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
      send_seq(frame);
      idle(1);
      chk("empty_load_done", 32'(load_done), 32'd1);
      chk("empty_load_err", 32'(load_err), 32'd0);
      chk("empty_core_reset_n", 32'(core_reset_n), 32'd1);
      chk("empty_words", 32'(words_loaded), 32'd0);
      halt_pulse();

      // 5. reset after 6 payload bytes
      push_wr(10'd0, 32'h0000_0013);
      frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
      send_seq(frame);
      idle(1);
      chk("mid_busy", 32'(busy), 32'd1);
      chk("mid_words", 32'(words_loaded), 32'd1);
      #2 reset_n = 1'b0;
      #1 chk_reset_vals("midrst");
      @(negedge clk);
      reset_n = 1'b1;

      // 6. stall inside a word
      frame = '{8'hA5, 8'h01, 8'h00, 8'h13};
      send_seq(frame);
`ifdef IMEM_BOOT_TIMEOUT_EN
      idle(20);
      chk("timeout_load_err", 32'(load_err), 32'd1);
      chk("timeout_busy", 32'(busy), 32'd0);
`else
      idle(1000);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_load_err", 32'(load_err), 32'd0);
`endif
      chk("stall_core_reset_n", 32'(core_reset_n), 32'd0);

      idle(2);
      chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
